// File: rtl/modem_pkg.sv
// rtl/modem_pkg.sv - shared symbol link constants, symbol type and tone lookup
// Purpose: single source for symbol length, tone half-periods and the
//          demodulator sample offsets, so both link ends agree.
// Contents: SYM_LEN, HALF_xx defaults, SAMPLE_OFF_0/1, sym_t, state_e,
//           half_of() symbol-to-half-period lookup.
package modem_pkg;

  localparam int SYM_LEN = 128;
  localparam int HALF_00 = 16;
  localparam int HALF_01 = 32;
  localparam int HALF_10 = 64;
  localparam int HALF_11 = 12;

  // Demodulator sample points, counted in cycles after the clk_symbol strobe.
  localparam int SAMPLE_OFF_0 = SYM_LEN / 8;
  localparam int SAMPLE_OFF_1 = 3 * SYM_LEN / 8;

  typedef logic [1:0] sym_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TONE = 1'b1
  } state_e;

  function automatic int half_of(input sym_t s, input int h00, input int h01,
                                 input int h10, input int h11);
    case (s)
      2'b00:   return h00;
      2'b01:   return h01;
      2'b10:   return h10;
      default: return h11;
    endcase
  endfunction

endpackage

// File: rtl/fsk_tone_gen.sv
// rtl/fsk_tone_gen.sv - square-wave tone generator (phase counter + toggle flop)
// Purpose: produces a square wave of programmable half-period.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load_i          latch half_m1_i as the active half-period minus one
//   half_m1_i       new half-period minus one
//   restart_i       restart phase at 0 with the output high
//   run_i           keep toggling; when low the output parks at 0
//   dout_o          registered square wave
module fsk_tone_gen #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] half_m1_i,
  input  logic          restart_i,
  input  logic          run_i,
  output logic          dout_o
);

  logic [CW-1:0] half_m1_q, half_m1_d;
  logic [CW-1:0] phase_q, phase_d;
  logic          dout_q, dout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_m1_q <= '0;
      phase_q   <= '0;
      dout_q    <= 1'b0;
    end else begin
      half_m1_q <= half_m1_d;
      phase_q   <= phase_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    half_m1_d = half_m1_q;
    phase_d   = phase_q;
    dout_d    = dout_q;
    if (load_i) half_m1_d = half_m1_i;
    // restart takes priority so a new symbol always begins high at phase 0
    if (restart_i) begin
      phase_d = '0;
      dout_d  = 1'b1;
    end else if (!run_i) begin
      phase_d = '0;
      dout_d  = 1'b0;
    end else if (phase_q == half_m1_q) begin
      phase_d = '0;
      dout_d  = ~dout_q;
    end else begin
      phase_d = phase_q + CW'(1);
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/fsk_modulator.sv
// rtl/fsk_modulator.sv - 4-tone square-wave FSK modulator, link transmit end
// Purpose: accepts 2-bit symbols on a valid/ready handshake and emits one
//          SYM_LEN-cycle tone per symbol with a strobe in its first cycle.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   sym_in          symbol, sampled on accept
//   sym_valid       sym_in valid
//   sym_ready       can accept this cycle (IDLE or last cycle of a symbol)
//   dout            registered square wave
//   clk_symbol      registered strobe in cycle 0 of each symbol
//   busy            high while in TONE
module fsk_modulator #(
  parameter int SYM_LEN = modem_pkg::SYM_LEN,
  parameter int HALF_00 = modem_pkg::HALF_00,
  parameter int HALF_01 = modem_pkg::HALF_01,
  parameter int HALF_10 = modem_pkg::HALF_10,
  parameter int HALF_11 = modem_pkg::HALF_11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       dout,
  output logic       clk_symbol,
  output logic       busy
);

  import modem_pkg::*;

  localparam int CW = $clog2(SYM_LEN);

  state_e        state_q, state_d;
  logic [CW-1:0] sym_cnt_q, sym_cnt_d;
  logic          clk_symbol_q;
  logic          accept;
  logic          last_cyc;
  logic [CW-1:0] half_m1;

  assign last_cyc = (sym_cnt_q == CW'(SYM_LEN - 1));
  assign accept   = sym_valid & sym_ready;
  // HALF_xx <= SYM_LEN, so half-1 always fits in CW bits
  assign half_m1  = CW'(half_of(sym_t'(sym_in), HALF_00, HALF_01, HALF_10, HALF_11) - 1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sym_cnt_q    <= '0;
      clk_symbol_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      clk_symbol_q <= accept;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_TONE;
      ST_TONE: if (last_cyc && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sym_cnt_d = '0;
    if (!accept && state_q == ST_TONE) sym_cnt_d = sym_cnt_q + CW'(1);
  end

  // Output logic
  always_comb begin
    sym_ready = (state_q == ST_IDLE) || last_cyc;
    busy      = (state_q == ST_TONE);
  end

  fsk_tone_gen #(
    .CW(CW)
  ) u_tone (
    .clk       (clk),
    .rst       (reset),
    .load_i    (accept),
    .half_m1_i (half_m1),
    .restart_i (accept),
    .run_i     (state_d == ST_TONE),
    .dout_o    (dout)
  );

  assign clk_symbol = clk_symbol_q;

endmodule

// File: tb/tb_fsk_modulator.sv
// tb/tb_fsk_modulator.sv - self-checking bench for fsk_modulator
module tb_fsk_modulator;
  import modem_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sym_in = 2'b00;
  logic       sym_valid = 1'b0;
  logic       sym_ready, dout, clk_symbol, busy;

  int n_chk = 0;
  int n_fail = 0;

  fsk_modulator dut (
    .clk        (clk),
    .reset      (reset),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .dout       (dout),
    .clk_symbol (clk_symbol),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_dout(input int k, input int half);
    return ((k / half) % 2) == 0;
  endfunction

  // ---------------- scoreboard: demodulator model ----------------
  logic [1:0] exp_q[$];
  int         cyc = 0;
  int         strobe_cyc = -1;
  logic       s0 = 1'b0;

  always @(negedge clk) begin
    logic [1:0] got, want;
    cyc++;
    if (reset) begin
      exp_q.delete();
      strobe_cyc = -1;
    end else begin
      if (clk_symbol) strobe_cyc = cyc;
      if (strobe_cyc >= 0 && cyc - strobe_cyc == 16) s0 = dout;
      if (strobe_cyc >= 0 && cyc - strobe_cyc == 48) begin
        case ({s0, dout})
          2'b00:   got = 2'b00;
          2'b10:   got = 2'b01;
          2'b11:   got = 2'b10;
          default: got = 2'b11;
        endcase
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_symbol", 1, 0);
        end else begin
          want = exp_q.pop_front();
          chk("sb_demod_symbol", got, want);
        end
      end
      if (sym_valid && sym_ready) exp_q.push_back(sym_in);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ready(input int max);
    int n = 0;
    while (!sym_ready && n < max) begin
      tick();
      n++;
    end
    if (n == max) chk("ready_timeout", sym_ready, 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    if (n == max) chk("idle_timeout", busy, 0);
  endtask

  typedef struct {
    logic [1:0] sym;
    int         half;
    logic       e0;
    logic       e1;
  } vec_t;

  // single symbol from IDLE, full waveform check through return to IDLE
  task automatic send_and_check(input vec_t v, input string tag);
    int bad_w = 0, bad_s = 0, bad_r = 0, bad_b = 0;
    logic d16 = 1'b0, d48 = 1'b0;
    chk({tag, "_ready_idle"}, sym_ready, 1);
    sym_in = v.sym;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    for (int k = 0; k < 128; k++) begin
      if (dout !== exp_dout(k, v.half)) bad_w++;
      if (clk_symbol !== (k == 0)) bad_s++;
      if (sym_ready !== (k == 127)) bad_r++;
      if (busy !== 1'b1) bad_b++;
      if (k == 16) d16 = dout;
      if (k == 48) d48 = dout;
      tick();
    end
    chk({tag, "_wave_errs"}, bad_w, 0);
    chk({tag, "_strobe_errs"}, bad_s, 0);
    chk({tag, "_ready_errs"}, bad_r, 0);
    chk({tag, "_busy_errs"}, bad_b, 0);
    chk({tag, "_sample16"}, d16, v.e0);
    chk({tag, "_sample48"}, d48, v.e1);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_dout"}, dout, 0);
    chk({tag, "_end_ready"}, sym_ready, 1);
  endtask

  initial begin
    vec_t vecs[4];
    logic [1:0] seq[4];
    realtime t_prev;
    int bad;

    vecs[0] = '{2'b01, 32, 1'b1, 1'b0};
    vecs[1] = '{2'b00, 16, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 64, 1'b1, 1'b1};
    vecs[3] = '{2'b11, 12, 1'b0, 1'b1};

    // 1: reset and idle
    tick();
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_strobe", clk_symbol, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", sym_ready, 1);
    reset = 1'b0;
    bad = 0;
    repeat (500) begin
      tick();
      if (dout !== 1'b0 || clk_symbol !== 1'b0 || busy !== 1'b0 || sym_ready !== 1'b1) bad++;
    end
    chk("idle_500_errs", bad, 0);

    // 2: single symbols from the table
    for (int i = 0; i < 4; i++) send_and_check(vecs[i], $sformatf("single%0d", i));

    // 3: back-to-back 00,01,10,11, strobes 128 cycles apart
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b11;
    t_prev = 0;
    sym_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sym_in = seq[i];
      wait_ready(200);
      tick();
      chk($sformatf("b2b_strobe%0d", i), clk_symbol, 1);
      if (i > 0) chk($sformatf("b2b_spacing%0d", i), int'(($realtime - t_prev) / 10.0), 128);
      t_prev = $realtime;
    end
    sym_valid = 1'b0;
    wait_idle(300);

    // 4: sym_in churns mid-symbol, tone must not change
    sym_in = 2'b10;
    sym_valid = 1'b1;
    tick();
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      sym_in = (k == 127) ? 2'b00 : 2'($urandom_range(0, 3));
      if (sym_ready !== (k == 127)) bad++;
      if (dout !== exp_dout(k, 64)) bad++;
      tick();
    end
    chk("churn_errs", bad, 0);
    chk("churn_next_strobe", clk_symbol, 1);
    sym_valid = 1'b0;
    wait_idle(300);

    // 5: reset at sym_cnt=40 of symbol 10
    sym_in = 2'b10;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    repeat (40) tick();
    chk("midrst_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_dout", dout, 0);
    chk("midrst_strobe", clk_symbol, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", sym_ready, 1);
    tick();
    tick();
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      tick();
      if (clk_symbol !== 1'b0 || dout !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("postrst_quiet_errs", bad, 0);
    send_and_check(vecs[0], "postrst");

    // simultaneous reset and accept drops the symbol
    sym_in = 2'b11;
    sym_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sym_valid = 1'b0;
    tick();
    chk("rstacc_strobe", clk_symbol, 0);
    chk("rstacc_busy", busy, 0);

    // 6: random loopback with random gaps
    for (int n = 0; n < 500; n++) begin
      sym_in = 2'($urandom_range(0, 3));
      sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      wait_ready(200);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end
    wait_idle(300);
    repeat (60) tick();
    chk("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
